// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage: bus layouts,
// load-op bit positions and exception codes.
package mem_stage_pkg;

  localparam int LD_B  = 0;
  localparam int LD_BU = 1;
  localparam int LD_H  = 2;
  localparam int LD_HU = 3;
  localparam int LD_W  = 4;

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_PIL = 6'h01;
  localparam logic [5:0] ECODE_PIS = 6'h02;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0b;
  localparam logic [5:0] ECODE_BRK = 6'h0c;
  localparam logic [5:0] ECODE_INE = 6'h0d;

  typedef struct packed {
    logic        mem_req;
    logic [4:0]  ld_op;
    logic        ex;
    logic [5:0]  ecode;
    logic        ertn;
    logic        csr_re;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wdata;
    logic [2:0]  tlb_op;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } es_to_ms_t;

  typedef struct packed {
    logic        ex;
    logic [5:0]  ecode;
    logic        ertn;
    logic        csr_re;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wdata;
    logic [2:0]  tlb_op;
    logic [31:0] vaddr;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_to_ws_t;

  typedef struct packed {
    logic        ex_or_ertn;
    logic        csr_re;
    logic        ld_pending;
    logic [4:0]  dest;
    logic        rf_we;
    logic [31:0] final_result;
  } ms_forward_t;

  localparam int ES_TO_MS_BUS_WD = $bits(es_to_ms_t);
  localparam int MS_TO_WS_BUS_WD = $bits(ms_to_ws_t);
  localparam int MS_FORWARD_WD   = $bits(ms_forward_t);

  function automatic logic is_load(input logic [4:0] op);
    return |op;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks byte/half/word by address low bits
// and sign/zero extends. Ports: ld_op, addr_lo, rdata -> data.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [4:0]  ld_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = 8'(rdata >> {addr_lo, 3'b000});
  assign half_v = 16'(rdata >> {addr_lo[1], 4'b0000});

  always_comb begin
    data = '0;
    unique case (1'b1)
      ld_op[LD_B]:  data = {{24{byte_v[7]}}, byte_v};
      ld_op[LD_BU]: data = {24'b0, byte_v};
      ld_op[LD_H]:  data = {{16{half_v[15]}}, half_v};
      ld_op[LD_HU]: data = {16'b0, half_v};
      ld_op[LD_W]:  data = rdata;
      default:      data = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: waits for data response, aligns loads,
// drops stale responses after flush, drives WB and ID forward.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DISCARD_W = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_FORWARD_WD-1:0]   ms_forward,
  input  logic                       back_ertn_flush,
  input  logic                       back_ex,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata
);

  localparam logic [DISCARD_W-1:0] CNT_MAX = '1;

  es_to_ms_t             ms_bus;
  logic                  ms_valid;
  logic [DISCARD_W-1:0]  discard_cnt;
  logic                  buf_valid;
  logic [31:0]           buf_data;

  logic        flush;
  logic        cnt_zero;
  logic        ok_live;
  logic        ms_ready_go;
  logic        ms_leave;
  logic        cnt_inc;
  logic        cnt_dec;
  logic        buf_load;
  logic [31:0] ld_data;
  logic [31:0] aligned;
  logic [31:0] final_result;
  logic        ld_pending;

  ms_to_ws_t   ws_out;
  ms_forward_t fw_out;

  assign flush    = back_ex | back_ertn_flush;
  assign cnt_zero = (discard_cnt == '0);

  // A response only belongs to us once every stale one is gone.
  assign ok_live = data_sram_data_ok & cnt_zero;

  assign ms_ready_go = ~ms_bus.mem_req | buf_valid | ok_live;
  assign ms_allowin  = ~ms_valid | (ms_ready_go & ws_allowin);
  assign ms_leave    = ms_valid & ms_ready_go & ws_allowin;

  assign ms_to_ws_valid = ms_valid & ms_ready_go & ~flush;

  // Flushed request still waiting: its response will come later.
  assign cnt_inc = flush & ms_valid & ms_bus.mem_req
                 & ~buf_valid & ~ok_live;
  assign cnt_dec = data_sram_data_ok & ~cnt_zero;

  assign buf_load = ms_valid & ms_bus.mem_req
                  & ~buf_valid & ok_live;

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid <= 1'b0;
    end else if (flush) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_bus <= '0;
    end else if (es_to_ms_valid && ms_allowin) begin
      ms_bus <= es_to_ms_t'(es_to_ms_bus);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      discard_cnt <= '0;
    end else if (cnt_inc && cnt_dec) begin
      discard_cnt <= discard_cnt;
    end else if (cnt_inc && discard_cnt != CNT_MAX) begin
      discard_cnt <= discard_cnt + 1'b1;
    end else if (cnt_dec) begin
      discard_cnt <= discard_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_data  <= '0;
    end else if (flush || ms_leave) begin
      buf_valid <= 1'b0;
    end else if (buf_load) begin
      buf_valid <= 1'b1;
      buf_data  <= data_sram_rdata;
    end
  end

  assign ld_data = buf_valid ? buf_data : data_sram_rdata;

  mem_stage_load_align u_align (
    .ld_op   (ms_bus.ld_op),
    .addr_lo (ms_bus.result[1:0]),
    .rdata   (ld_data),
    .data    (aligned)
  );

  assign final_result = is_load(ms_bus.ld_op)
                      ? aligned : ms_bus.result;

  assign ld_pending = ms_valid & is_load(ms_bus.ld_op)
                    & ~ms_ready_go;

  always_comb begin
    ws_out              = '0;
    ws_out.ex           = ms_bus.ex;
    ws_out.ecode        = ms_bus.ecode;
    ws_out.ertn         = ms_bus.ertn;
    ws_out.csr_re       = ms_bus.csr_re;
    ws_out.csr_we       = ms_bus.csr_we;
    ws_out.csr_num      = ms_bus.csr_num;
    ws_out.csr_wdata    = ms_bus.csr_wdata;
    ws_out.tlb_op       = ms_bus.tlb_op;
    ws_out.vaddr        = ms_bus.result;
    ws_out.gr_we        = ms_bus.gr_we;
    ws_out.dest         = ms_bus.dest;
    ws_out.final_result = final_result;
    ws_out.pc           = ms_bus.pc;
  end

  always_comb begin
    fw_out              = '0;
    fw_out.ex_or_ertn   = (ms_bus.ex | ms_bus.ertn) & ms_valid;
    fw_out.csr_re       = ms_bus.csr_re & ms_valid;
    fw_out.ld_pending   = ld_pending;
    fw_out.dest         = ms_bus.dest;
    fw_out.rf_we        = ms_bus.gr_we & ms_valid & ~ms_bus.ex;
    fw_out.final_result = final_result;
  end

  assign ms_to_ws_bus = ws_out;
  assign ms_forward   = fw_out;

endmodule
